// File: rtl/modinv_809.sv
// Sequential modular inverter: dout_r = din_a^(MOD-2) mod MOD by left-to-right
// square-and-multiply, one Barrett-reduced modular multiply per clock.
module modinv_809 #(
   parameter int unsigned MOD = 809,
   parameter int unsigned W   = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] din_a,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [W-1:0] dout_r
);

   localparam int unsigned W2 = 2 * W;
   localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [W-1:0]  MOD_N = W'(MOD);
   localparam logic [W2-1:0] MOD_W = W2'(MOD);
   localparam logic [W-1:0]  EXP   = W'(MOD - 2);
   localparam logic [W2-1:0] MU    = W2'((64'd1 << W2) / MOD);

   typedef enum logic [1:0] {StIdle, StSqr, StMul, StErr} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  base_q, base_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [W-1:0]  dout_q, dout_d;
   logic [W-1:0]  mul_b;
   logic [W-1:0]  prod;
   logic          fin;

   // Barrett estimate undershoots the true quotient by at most 2, hence two corrections.
   function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W2-1:0]   x;
      logic [2*W2-1:0] t;
      logic [W2-1:0]   q;
      logic [W2-1:0]   r;
      x = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      t = {{W2{1'b0}}, x} * {{W2{1'b0}}, MU};
      q = W2'(t >> W2);
      r = x - q * MOD_W;
      if (r >= MOD_W) r = r - MOD_W;
      if (r >= MOD_W) r = r - MOD_W;
      return W'(r);
   endfunction

   assign mul_b = (state_q == StMul) ? base_q : acc_q;
   assign prod  = mod_mul(acc_q, mul_b);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      base_d  = base_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      dout_d  = dout_q;
      fin     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               busy_d = 1'b1;
               if (din_a == '0 || din_a >= MOD_N) begin
                  state_d = StErr;
               end else begin
                  base_d  = din_a;
                  acc_d   = W'(1);
                  idx_d   = IW'(W - 1);
                  state_d = StSqr;
               end
            end
         end
         StSqr: begin
            acc_d = prod;
            if (EXP[idx_q]) begin
               state_d = StMul;
            end else if (idx_q == '0) begin
               fin = 1'b1;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         StMul: begin
            acc_d = prod;
            if (idx_q == '0) begin
               fin = 1'b1;
            end else begin
               idx_d   = idx_q - IW'(1);
               state_d = StSqr;
            end
         end
         StErr: begin
            dout_d  = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Final op result goes straight to the output register on the same edge.
      if (fin) begin
         dout_d  = prod;
         done_d  = 1'b1;
         busy_d  = 1'b0;
         err_d   = 1'b0;
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= W'(1);
         base_q  <= '0;
         idx_q   <= IW'(W - 1);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign dout_r = dout_q;

endmodule

// File: tb/tb_modinv_809.sv
// Self-checking bench for modinv_809: directed cases plus a randomized full sweep
// against a plain modular-exponentiation reference.
module tb_modinv_809;

   localparam int MOD = 809;
   localparam int LAT = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [9:0] din_a = '0;
   logic       busy, done, err;
   logic [9:0] dout_r;

   int n_checks = 0;
   int n_fail = 0;

   modinv_809 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .din_a (din_a),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .dout_r(dout_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Fermat inverse by repeated multiplication; 0 for illegal operands.
   function automatic int ref_inv(input int a);
      int r;
      if (a <= 0 || a >= MOD) return 0;
      r = 1;
      for (int k = 0; k < MOD - 2; k++) r = (r * a) % MOD;
      return r;
   endfunction

   // Issue one operation. With b2b the start is raised in the current (done) cycle.
   // inject pulses start with din_a=7 at cycles 4 and 10 while busy.
   task automatic do_op(input int a, input bit b2b, input bit inject,
                        output int lat, output int res, output int e, output int bcnt);
      if (!b2b) @(negedge clk);
      start = 1'b1;
      din_a = 10'(a);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         if (inject && (lat == 4 || lat == 10)) begin
            start = 1'b1;
            din_a = 10'd7;
         end else begin
            start = 1'b0;
            din_a = 10'($urandom_range(0, 1023));
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      res = int'(dout_r);
      e = int'(err);
   endtask

   task automatic op_check(input int a, input bit b2b, input bit inject);
      int lat, res, e, bcnt, exp_lat;
      bit legal;
      legal = (a > 0 && a < MOD);
      exp_lat = legal ? LAT : 1;
      do_op(a, b2b, inject, lat, res, e, bcnt);
      check($sformatf("latency a=%0d", a), lat, exp_lat);
      check($sformatf("busy_cycles a=%0d", a), bcnt, exp_lat);
      check($sformatf("dout a=%0d", a), res, ref_inv(a));
      check($sformatf("err a=%0d", a), e, legal ? 0 : 1);
      if (legal) check($sformatf("a*inv a=%0d", a), (a * res) % MOD, 1);
   endtask

   initial begin
      int extra;
      #3 rst_n = 1'b0;
      #1;
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset err", int'(err), 0);
      check("reset dout", int'(dout_r), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      op_check(2, 1'b0, 1'b0);
      op_check(1, 1'b1, 1'b0);
      op_check(3, 1'b1, 1'b0);
      op_check(5, 1'b1, 1'b0);
      op_check(808, 1'b1, 1'b0);
      @(negedge clk);
      check("done single-cycle", int'(done), 0);

      op_check(0, 1'b0, 1'b0);
      @(negedge clk);
      check("err held", int'(err), 1);
      check("err dout held", int'(dout_r), 0);
      op_check(809, 1'b0, 1'b0);
      op_check(1023, 1'b0, 1'b0);
      op_check(2, 1'b0, 1'b0);

      op_check(3, 1'b0, 1'b1);
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("no extra done", extra, 0);

      // Reset mid-operation.
      @(negedge clk);
      start = 1'b1;
      din_a = 10'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst busy", int'(busy), 0);
      check("midrst done", int'(done), 0);
      check("midrst err", int'(err), 0);
      check("midrst dout", int'(dout_r), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("aborted no done", extra, 0);
      op_check(5, 1'b0, 1'b0);

      // Full legal sweep with random back-to-back spacing and sprinkled illegal operands.
      for (int a = 1; a < MOD; a++) begin
         op_check(a, 1'($urandom_range(0, 1)), 1'b0);
         if ($urandom_range(0, 99) == 0) op_check($urandom_range(809, 1023), 1'b1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/modinv_809.md
Name: modinv_809

Overview:
- Sequential modular inverter over GF(809), using Fermat's little theorem: dout_r = din_a^(MOD-2) mod MOD.
- Computed by left-to-right square-and-multiply, one modular multiply per clock.
- Sits beside the mod-809 Barrett reduction datapath. It takes a reduced residue and returns its multiplicative inverse, for division and normalisation steps in the field arithmetic.

Parameters:
- MOD, 809, prime modulus; legal range 3..1023.
- W, 10, residue width; MOD must be < 2^W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when busy=0
- din_a  input  W  operand residue
- busy  output  1  high while a computation is in flight
- done  output  1  one-cycle pulse; result/err valid from this cycle
- err  output  1  operand illegal (0 or >= MOD); valid with done, held until next accepted start
- dout_r  output  W  inverse, held until the next accepted start

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy=0, done=0, err=0, dout_r=0.
  - Internal acc=1, base=0, bit index=W-1.
- States and transitions:
  - IDLE: start=1 and din_a legal -> latch base=din_a, acc=1, idx=W-1, busy=1; go to SQR.
  - IDLE, illegal operand: start=1 with din_a==0 or din_a>=MOD -> go to ERR; busy=1.
  - SQR: acc <= acc*acc mod MOD. If E[idx]=1 go to MUL. Otherwise: if idx==0, finish; else idx--, stay SQR.
  - MUL: acc <= acc*base mod MOD. If idx==0 finish; else idx--, go to SQR.
  - Finish: on the edge performing the last op, dout_r <= new acc, done <= 1, busy <= 0, err <= 0; return to IDLE.
  - ERR: one cycle. dout_r <= 0, err <= 1, done <= 1, busy <= 0; return to IDLE.
- Exponent: E = MOD-2 as a W-bit constant; all W bits are processed including leading zeros.
- Latency:
  - Latency = W + popcount(MOD-2) op cycles. With the defaults E=807=1100100111b, which gives 10 squares + 6 multiplies = 16.
  - The edge sampling start is edge 0; done is high in the cycle after edge 16.
  - Error case: done high after edge 1.
- Arithmetic:
  - Products are at most 808^2 = 652864 and need a 20-bit intermediate (2W bits in general).
  - Reduction must be exact for every x in [0, (MOD-1)^2]. Barrett with mu = floor(2^(2W)/MOD) and up to two conditional subtractions, or equivalent, is acceptable.
  - The combinational multiply+reduce path fits in one cycle.
- Busy handling:
  - start while busy=1 is ignored, with no queuing.
  - din_a is sampled only on the accepted start edge; later changes have no effect.
- done is never high for more than one consecutive cycle.
- Back-to-back: start may be asserted in the same cycle done is high (busy=0 then) and is accepted.
- Reset mid-operation: all state returns to reset values immediately and no done is produced for the aborted operation.
- din_a=1 is legal and follows the full 16-cycle path.

Test Plan:
- Reset, then start with din_a=2 -> done exactly 16 cycles after start edge, dout_r=405, err=0; busy high for those 16 cycles.
- Sequence din_a=1, 3, 5, 808 (each started on its predecessor's done cycle) -> dout_r=1, 270, 162, 808 in order; no idle gap, each 16 cycles.
- start with din_a=0, then din_a=809, then din_a=1023 -> each gives done 1 cycle later with err=1, dout_r=0. A following legal din_a=2 clears err and returns 405.
- Start din_a=3; pulse start with din_a=7 at cycles 4 and 10 -> ignored; result 270 at cycle 16; no extra done.
- Start din_a=5; assert rst_n=0 at cycle 8 for 2 cycles -> outputs 0 immediately, no done. Then start din_a=5 -> 162 after 16 cycles.
- Exhaustive sweep of din_a=1..808 -> (din_a*dout_r) mod 809 == 1 for all, and latency constant at 16.
